// File: rtl/cnn_core.sv
// cnn_core: single-layer binary-image CNN classifier.
//   Three 4x4 conv kernels (stride 1) with bias, ReLU and saturation to 0..127,
//   2x2 max-pool, flatten, then a 432-input fully-connected layer with bias,
//   producing one signed 8-bit score.
// Ports:
//   clk                          - sole clock, rising edge
//   rst_cnn                      - synchronous active-high reset of the whole block
//   image_input                  - binary image, image_input[row][col]
//   feature_weights_input        - one 4x4 kernel, row-major, signed 8-bit
//   feature_writeAddr/_WrEn      - kernel index 0..2, active-low write (IDLE only)
//   bias_weights_input/bias_WrEn - [0..2] conv biases, [3] FC bias, active-low write
//   fullyconnected_weights_input - 16 FC weights for row fullyconnected_writeAddr (0..26)
//   fullyconnected_WrEn          - active-low FC row write (IDLE only)
//   convolution_enable           - active-low start strobe (IDLE only)
//   cnn_output                   - signed score, held until the next run completes
module cnn_core #(
    parameter int IMAGE_WIDTH               = 28,
    parameter int IMAGE_HEIGHT              = 28,
    parameter int NUM_FEATURES              = 3,
    parameter int KERNEL_SIZE               = 4,
    parameter int DATA_WIDTH                = 8,
    parameter int PSUM_DATA_WIDTH           = 12,
    parameter int FULLYCONNECTED_DATA_WIDTH = 32
) (
    input  logic                                                clk,
    input  logic                                                rst_cnn,
    input  logic [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0]            image_input,
    input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  feature_weights_input,
    input  logic [1:0]                                          feature_writeAddr,
    input  logic                                                feature_WrEn,
    input  logic [NUM_FEATURES:0][DATA_WIDTH-1:0]               bias_weights_input,
    input  logic                                                bias_WrEn,
    input  logic [15:0][DATA_WIDTH-1:0]                         fullyconnected_weights_input,
    input  logic [4:0]                                          fullyconnected_writeAddr,
    input  logic                                                fullyconnected_WrEn,
    input  logic                                                convolution_enable,
    output logic [DATA_WIDTH-1:0]                               cnn_output
);

    localparam int CONVOLUTION_WIDTH  = IMAGE_WIDTH - KERNEL_SIZE + 1;
    localparam int CONVOLUTION_HEIGHT = IMAGE_HEIGHT - KERNEL_SIZE + 1;
    localparam int POOLED_WIDTH       = CONVOLUTION_WIDTH >> 1;
    localparam int POOLED_HEIGHT      = CONVOLUTION_HEIGHT >> 1;
    localparam int POOLED_AREA        = POOLED_WIDTH * POOLED_HEIGHT;
    localparam int FLATTENED_LENGTH   = POOLED_AREA * NUM_FEATURES;
    localparam int KK                 = KERNEL_SIZE * KERNEL_SIZE;
    localparam int FC_LANES           = 16;
    localparam int FC_ROWS            = FLATTENED_LENGTH / FC_LANES;
    localparam int FCW                = FULLYCONNECTED_DATA_WIDTH;
    localparam int CONV_CNT_W         = $clog2(CONVOLUTION_WIDTH);
    localparam int POOL_CNT_W         = $clog2(POOLED_WIDTH);
    localparam int FC_CNT_W           = $clog2(FC_ROWS);

    localparam logic signed [PSUM_DATA_WIDTH:0] CONV_MAX = 127;
    localparam logic signed [FCW:0]             OUT_MAX  = 127;
    localparam logic signed [FCW:0]             OUT_MIN  = -128;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StConv     = 3'd1,
        StPool     = 3'd2,
        StFlatten  = 3'd3,
        StFc       = 3'd4,
        StOutput   = 3'd5
    } state_t;

    state_t state;

    logic signed [DATA_WIDTH-1:0] feature_weights [NUM_FEATURES][KK];
    logic signed [DATA_WIDTH-1:0] bias_weights    [NUM_FEATURES+1];
    logic signed [DATA_WIDTH-1:0] fc_weights      [FLATTENED_LENGTH];

    logic [IMAGE_HEIGHT-1:0][IMAGE_WIDTH-1:0] image_q;

    // Intermediate maps, kept as plain arrays so they can be inspected by name.
    logic [DATA_WIDTH-1:0] convolution_outfmap [NUM_FEATURES][CONVOLUTION_HEIGHT][CONVOLUTION_WIDTH];
    logic [DATA_WIDTH-1:0] pooled_outfmap      [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH];
    logic [DATA_WIDTH-1:0] flattened_outfmap   [FLATTENED_LENGTH];

    logic [CONV_CNT_W-1:0] conv_row, conv_col;
    logic [POOL_CNT_W-1:0] pool_i, pool_j;
    logic [FC_CNT_W-1:0]   fc_idx;
    logic signed [FCW-1:0] fc_acc;

    function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Convolution datapath: all kernels at the current (conv_row, conv_col).
    logic signed [PSUM_DATA_WIDTH-1:0] psum        [NUM_FEATURES];
    logic signed [PSUM_DATA_WIDTH:0]   conv_biased [NUM_FEATURES];
    logic [DATA_WIDTH-1:0]             conv_val    [NUM_FEATURES];

    always_comb begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
            psum[f] = '0;
            for (int kr = 0; kr < KERNEL_SIZE; kr++) begin
                for (int kc = 0; kc < KERNEL_SIZE; kc++) begin
                    if (image_q[int'(conv_row) + kr][int'(conv_col) + kc]) begin
                        psum[f] = psum[f] +
                            PSUM_DATA_WIDTH'(feature_weights[f][kr*KERNEL_SIZE + kc]);
                    end
                end
            end
            // One extra bit so psum + bias cannot wrap before the clamp.
            conv_biased[f] = (PSUM_DATA_WIDTH+1)'(psum[f]) +
                             (PSUM_DATA_WIDTH+1)'(bias_weights[f]);
            if (conv_biased[f][PSUM_DATA_WIDTH]) begin
                conv_val[f] = '0;
            end else if (conv_biased[f] > CONV_MAX) begin
                conv_val[f] = DATA_WIDTH'(CONV_MAX);
            end else begin
                conv_val[f] = conv_biased[f][DATA_WIDTH-1:0];
            end
        end
    end

    // Pooling datapath: 2x2 window at (2*pool_i, 2*pool_j); last conv row/col never touched.
    logic [DATA_WIDTH-1:0] pool_val [NUM_FEATURES];

    always_comb begin
        for (int f = 0; f < NUM_FEATURES; f++) begin
            pool_val[f] = max2(
                max2(convolution_outfmap[f][2*int'(pool_i)][2*int'(pool_j)],
                     convolution_outfmap[f][2*int'(pool_i)][2*int'(pool_j)+1]),
                max2(convolution_outfmap[f][2*int'(pool_i)+1][2*int'(pool_j)],
                     convolution_outfmap[f][2*int'(pool_i)+1][2*int'(pool_j)+1]));
        end
    end

    // FC datapath: 16 MACs on row fc_idx. Map values are 0..127 so treating them as signed is safe.
    logic signed [2*DATA_WIDTH-1:0] fc_prod [FC_LANES];
    logic signed [FCW-1:0]          fc_sum;

    always_comb begin
        fc_sum = '0;
        for (int k = 0; k < FC_LANES; k++) begin
            fc_prod[k] =
                (2*DATA_WIDTH)'($signed(flattened_outfmap[int'(fc_idx)*FC_LANES + k])) *
                (2*DATA_WIDTH)'(fc_weights[int'(fc_idx)*FC_LANES + k]);
            fc_sum = fc_sum + FCW'(fc_prod[k]);
        end
    end

    logic signed [FCW:0]     out_sum;
    logic [DATA_WIDTH-1:0]   out_val;

    always_comb begin
        out_sum = (FCW+1)'(fc_acc) + (FCW+1)'(bias_weights[NUM_FEATURES]);
        if (out_sum > OUT_MAX) begin
            out_val = DATA_WIDTH'(OUT_MAX);
        end else if (out_sum < OUT_MIN) begin
            out_val = DATA_WIDTH'(OUT_MIN);
        end else begin
            out_val = out_sum[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_cnn) begin
            state      <= StIdle;
            cnn_output <= '0;
            image_q    <= '0;
            conv_row   <= '0;
            conv_col   <= '0;
            pool_i     <= '0;
            pool_j     <= '0;
            fc_idx     <= '0;
            fc_acc     <= '0;
            for (int f = 0; f < NUM_FEATURES; f++) begin
                for (int k = 0; k < KK; k++) feature_weights[f][k] <= '0;
                for (int r = 0; r < CONVOLUTION_HEIGHT; r++)
                    for (int c = 0; c < CONVOLUTION_WIDTH; c++)
                        convolution_outfmap[f][r][c] <= '0;
                for (int i = 0; i < POOLED_HEIGHT; i++)
                    for (int j = 0; j < POOLED_WIDTH; j++)
                        pooled_outfmap[f][i][j] <= '0;
            end
            for (int b = 0; b <= NUM_FEATURES; b++) bias_weights[b] <= '0;
            for (int n = 0; n < FLATTENED_LENGTH; n++) begin
                fc_weights[n]        <= '0;
                flattened_outfmap[n] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (!feature_WrEn && int'(feature_writeAddr) < NUM_FEATURES) begin
                        for (int k = 0; k < KK; k++)
                            feature_weights[feature_writeAddr][k] <= feature_weights_input[k];
                    end
                    if (!bias_WrEn) begin
                        for (int b = 0; b <= NUM_FEATURES; b++)
                            bias_weights[b] <= bias_weights_input[b];
                    end
                    if (!fullyconnected_WrEn && int'(fullyconnected_writeAddr) < FC_ROWS) begin
                        for (int k = 0; k < FC_LANES; k++)
                            fc_weights[int'(fullyconnected_writeAddr)*FC_LANES + k] <=
                                fullyconnected_weights_input[k];
                    end
                    if (!convolution_enable) begin
                        image_q  <= image_input;
                        conv_row <= '0;
                        conv_col <= '0;
                        pool_i   <= '0;
                        pool_j   <= '0;
                        fc_idx   <= '0;
                        fc_acc   <= '0;
                        state    <= StConv;
                    end
                end
                StConv: begin
                    for (int f = 0; f < NUM_FEATURES; f++)
                        convolution_outfmap[f][conv_row][conv_col] <= conv_val[f];
                    if (conv_col == CONV_CNT_W'(CONVOLUTION_WIDTH - 1)) begin
                        conv_col <= '0;
                        if (conv_row == CONV_CNT_W'(CONVOLUTION_HEIGHT - 1)) state <= StPool;
                        else conv_row <= conv_row + 1'b1;
                    end else begin
                        conv_col <= conv_col + 1'b1;
                    end
                end
                StPool: begin
                    for (int f = 0; f < NUM_FEATURES; f++)
                        pooled_outfmap[f][pool_i][pool_j] <= pool_val[f];
                    if (pool_j == POOL_CNT_W'(POOLED_WIDTH - 1)) begin
                        pool_j <= '0;
                        if (pool_i == POOL_CNT_W'(POOLED_HEIGHT - 1)) state <= StFlatten;
                        else pool_i <= pool_i + 1'b1;
                    end else begin
                        pool_j <= pool_j + 1'b1;
                    end
                end
                StFlatten: begin
                    for (int f = 0; f < NUM_FEATURES; f++)
                        for (int i = 0; i < POOLED_HEIGHT; i++)
                            for (int j = 0; j < POOLED_WIDTH; j++)
                                flattened_outfmap[f*POOLED_AREA + i*POOLED_WIDTH + j] <=
                                    pooled_outfmap[f][i][j];
                    state <= StFc;
                end
                StFc: begin
                    fc_acc <= fc_acc + fc_sum;
                    if (fc_idx == FC_CNT_W'(FC_ROWS - 1)) state <= StOutput;
                    else fc_idx <= fc_idx + 1'b1;
                end
                StOutput: begin
                    cnn_output <= out_val;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_core.sv
module tb_cnn_core;

    logic              clk = 1'b0;
    logic              rst_cnn;
    logic [27:0][27:0] image_input;
    logic [15:0][7:0]  feature_weights_input;
    logic [1:0]        feature_writeAddr;
    logic              feature_WrEn;
    logic [3:0][7:0]   bias_weights_input;
    logic              bias_WrEn;
    logic [15:0][7:0]  fullyconnected_weights_input;
    logic [4:0]        fullyconnected_writeAddr;
    logic              fullyconnected_WrEn;
    logic              convolution_enable;
    logic [7:0]        cnn_output;

    always #5 clk = ~clk;

    cnn_core dut (
        .clk                          (clk),
        .rst_cnn                      (rst_cnn),
        .image_input                  (image_input),
        .feature_weights_input        (feature_weights_input),
        .feature_writeAddr            (feature_writeAddr),
        .feature_WrEn                 (feature_WrEn),
        .bias_weights_input           (bias_weights_input),
        .bias_WrEn                    (bias_WrEn),
        .fullyconnected_weights_input (fullyconnected_weights_input),
        .fullyconnected_writeAddr     (fullyconnected_writeAddr),
        .fullyconnected_WrEn          (fullyconnected_WrEn),
        .convolution_enable           (convolution_enable),
        .cnn_output                   (cnn_output)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int m_kern [3][16];
    int m_bias [4];
    int m_fc   [432];
    bit m_img  [28][28];
    int m_conv [3][25][25];
    int m_pool [3][12][12];
    int m_flat [432];
    int m_out;

    int kbuf [16];
    int fbuf [16];

    int  lat;
    bit  order_ok;
    int  n;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_compute();
        int s, acc;
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 25; r++)
                for (int c = 0; c < 25; c++) begin
                    s = m_bias[f];
                    for (int kr = 0; kr < 4; kr++)
                        for (int kc = 0; kc < 4; kc++)
                            if (m_img[r+kr][c+kc]) s += m_kern[f][kr*4 + kc];
                    m_conv[f][r][c] = clamp(s, 0, 127);
                end
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 12; i++)
                for (int j = 0; j < 12; j++) begin
                    s = m_conv[f][2*i][2*j];
                    if (m_conv[f][2*i][2*j+1] > s)   s = m_conv[f][2*i][2*j+1];
                    if (m_conv[f][2*i+1][2*j] > s)   s = m_conv[f][2*i+1][2*j];
                    if (m_conv[f][2*i+1][2*j+1] > s) s = m_conv[f][2*i+1][2*j+1];
                    m_pool[f][i][j] = s;
                    m_flat[f*144 + i*12 + j] = s;
                end
        acc = 0;
        for (int k = 0; k < 432; k++) acc += m_flat[k] * m_fc[k];
        m_out = clamp(acc + m_bias[3], -128, 127);
    endtask

    task automatic write_kernel(input int addr);
        @(negedge clk);
        feature_writeAddr = 2'(addr);
        for (int k = 0; k < 16; k++) feature_weights_input[k] = 8'(kbuf[k]);
        feature_WrEn = 1'b0;
        @(negedge clk);
        feature_WrEn = 1'b1;
        if (addr < 3) for (int k = 0; k < 16; k++) m_kern[addr][k] = kbuf[k];
    endtask

    task automatic write_bias(input int b0, input int b1, input int b2, input int b3);
        @(negedge clk);
        bias_weights_input[0] = 8'(b0);
        bias_weights_input[1] = 8'(b1);
        bias_weights_input[2] = 8'(b2);
        bias_weights_input[3] = 8'(b3);
        bias_WrEn = 1'b0;
        @(negedge clk);
        bias_WrEn = 1'b1;
        m_bias[0] = b0; m_bias[1] = b1; m_bias[2] = b2; m_bias[3] = b3;
    endtask

    task automatic write_fc_row(input int addr);
        @(negedge clk);
        fullyconnected_writeAddr = 5'(addr);
        for (int k = 0; k < 16; k++) fullyconnected_weights_input[k] = 8'(fbuf[k]);
        fullyconnected_WrEn = 1'b0;
        @(negedge clk);
        fullyconnected_WrEn = 1'b1;
        if (addr < 27) for (int k = 0; k < 16; k++) m_fc[addr*16 + k] = fbuf[k];
    endtask

    task automatic fill_kernel(input int addr, input int v);
        for (int k = 0; k < 16; k++) kbuf[k] = v;
        write_kernel(addr);
    endtask

    task automatic fill_fc(input int v);
        for (int k = 0; k < 16; k++) fbuf[k] = v;
        for (int a = 0; a < 27; a++) write_fc_row(a);
    endtask

    // Start strobe, then follow the run to IDLE; optionally pokes writes/start mid-run.
    task automatic run_inference(input bit disturb, output int latency, output bit in_order);
        int exp_seq [6] = '{1, 2, 3, 4, 5, 0};
        int idx, prev;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) m_img[r][c] = image_input[r][c];
        @(negedge clk);
        convolution_enable = 1'b0;
        @(negedge clk);
        convolution_enable = 1'b1;
        latency  = 0;
        idx      = 0;
        prev     = int'(dut.state);
        in_order = (prev == 1);
        while (int'(dut.state) != 0 && latency < 2000) begin
            if (disturb && latency == 100) begin
                for (int k = 0; k < 16; k++) begin
                    feature_weights_input[k]        = 8'd100;
                    fullyconnected_weights_input[k] = 8'd5;
                end
                for (int b = 0; b < 4; b++) bias_weights_input[b] = 8'd50;
                feature_writeAddr        = 2'd0;
                fullyconnected_writeAddr = 5'd0;
                feature_WrEn        = 1'b0;
                bias_WrEn           = 1'b0;
                fullyconnected_WrEn = 1'b0;
                convolution_enable  = 1'b0;
            end
            if (disturb && latency == 104) begin
                feature_WrEn        = 1'b1;
                bias_WrEn           = 1'b1;
                fullyconnected_WrEn = 1'b1;
                convolution_enable  = 1'b1;
            end
            @(negedge clk);
            latency++;
            if (int'(dut.state) != prev) begin
                idx++;
                if (idx > 5 || int'(dut.state) != exp_seq[idx]) in_order = 1'b0;
                prev = int'(dut.state);
            end
        end
        if (idx != 5) in_order = 1'b0;
        model_compute();
    endtask

    task automatic check_maps(input string tag);
        int bad_c, bad_p, bad_f;
        bad_c = 0; bad_p = 0; bad_f = 0;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 25; r++)
                for (int c = 0; c < 25; c++)
                    if (dut.convolution_outfmap[f][r][c] !== 8'(m_conv[f][r][c])) bad_c++;
            for (int i = 0; i < 12; i++)
                for (int j = 0; j < 12; j++)
                    if (dut.pooled_outfmap[f][i][j] !== 8'(m_pool[f][i][j])) bad_p++;
        end
        for (int k = 0; k < 432; k++)
            if (dut.flattened_outfmap[k] !== 8'(m_flat[k])) bad_f++;
        check({tag, "_conv_bad"}, bad_c, 0);
        check({tag, "_pool_bad"}, bad_p, 0);
        check({tag, "_flat_bad"}, bad_f, 0);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_latency"}, lat, 798);
        check({tag, "_state_order"}, 32'(order_ok), 1);
        check({tag, "_out"}, $signed(cnn_output), m_out);
        check_maps(tag);
    endtask

    task automatic check_cleared(input string tag);
        int nz;
        nz = 0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) if (dut.feature_weights[f][k] !== 8'd0) nz++;
            for (int r = 0; r < 25; r++)
                for (int c = 0; c < 25; c++)
                    if (dut.convolution_outfmap[f][r][c] !== 8'd0) nz++;
            for (int i = 0; i < 12; i++)
                for (int j = 0; j < 12; j++)
                    if (dut.pooled_outfmap[f][i][j] !== 8'd0) nz++;
        end
        for (int b = 0; b < 4; b++) if (dut.bias_weights[b] !== 8'd0) nz++;
        for (int k = 0; k < 432; k++) begin
            if (dut.fc_weights[k] !== 8'd0) nz++;
            if (dut.flattened_outfmap[k] !== 8'd0) nz++;
        end
        check({tag, "_state"}, 32'(int'(dut.state)), 0);
        check({tag, "_out"}, $signed(cnn_output), 0);
        check({tag, "_mem_nonzero"}, nz, 0);
    endtask

    task automatic clear_model();
        for (int f = 0; f < 3; f++) for (int k = 0; k < 16; k++) m_kern[f][k] = 0;
        for (int b = 0; b < 4; b++) m_bias[b] = 0;
        for (int k = 0; k < 432; k++) m_fc[k] = 0;
    endtask

    initial begin
        rst_cnn                      = 1'b1;
        image_input                  = '0;
        feature_weights_input        = '0;
        feature_writeAddr            = '0;
        feature_WrEn                 = 1'b1;
        bias_weights_input           = '0;
        bias_WrEn                    = 1'b1;
        fullyconnected_weights_input = '0;
        fullyconnected_writeAddr     = '0;
        fullyconnected_WrEn          = 1'b1;
        convolution_enable           = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_cnn = 1'b0;

        // Zero image: only biases reach the maps; FC all 1 saturates high.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) kbuf[k] = int'($urandom_range(255)) - 128;
            write_kernel(f);
        end
        write_bias(10, 0, 0, -8);
        fill_fc(1);
        image_input = '0;
        run_inference(1'b0, lat, order_ok);
        check_run("zero_img");
        check("zero_img_spec_out", $signed(cnn_output), 127);
        check("zero_img_f0", 32'(dut.convolution_outfmap[0][7][3]), 10);
        check("zero_img_flat143", 32'(dut.flattened_outfmap[143]), 10);
        check("zero_img_flat144", 32'(dut.flattened_outfmap[144]), 0);

        // FC all -1: acc -1440 plus bias -8 clamps to -128.
        fill_fc(-1);
        run_inference(1'b0, lat, order_ok);
        check_run("neg_fc");
        check("neg_fc_spec_out", $signed(cnn_output), -128);

        // All-ones image: f0 = 16+10, f1 ReLU to 0, f2 saturates at 127.
        fill_kernel(0, 1);
        fill_kernel(1, -127);
        fill_kernel(2, 127);
        write_bias(10, 0, 10, -8);
        image_input = '1;
        run_inference(1'b0, lat, order_ok);
        check_run("ones_img");
        check("ones_img_f0", 32'(dut.convolution_outfmap[0][12][12]), 26);
        check("ones_img_f1", 32'(dut.convolution_outfmap[1][0][24]), 0);
        check("ones_img_f2", 32'(dut.convolution_outfmap[2][24][0]), 127);

        // FC all zero: output is just the FC bias; a bare restart reproduces it.
        fill_fc(0);
        write_bias(int'($urandom_range(255)) - 128, 3, -3, -77);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) image_input[r][c] = 1'($urandom_range(1));
        run_inference(1'b0, lat, order_ok);
        check_run("fc_zero");
        check("fc_zero_spec_out", $signed(cnn_output), -77);
        run_inference(1'b0, lat, order_ok);
        check_run("rerun");

        // Random images and weights, plus writes to unused addresses that must be dropped.
        for (int t = 0; t < 3; t++) begin
            for (int f = 0; f < 4; f++) begin
                for (int k = 0; k < 16; k++) kbuf[k] = int'($urandom_range(80)) - 40;
                write_kernel(f);
            end
            write_bias(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
            for (int a = 0; a < 32; a++) begin
                for (int k = 0; k < 16; k++)
                    fbuf[k] = ($urandom_range(15) == 0) ? int'($urandom_range(6)) - 3 : 0;
                if (a >= 27) for (int k = 0; k < 16; k++) fbuf[k] = 99;
                write_fc_row(a);
            end
            n = int'($urandom_range(3));
            for (int r = 0; r < 28; r++)
                for (int c = 0; c < 28; c++)
                    image_input[r][c] = ($urandom_range(3) <= n) ? 1'b1 : 1'b0;
            run_inference(1'b0, lat, order_ok);
            check_run($sformatf("rand%0d", t));
        end

        // Writes and start pulses mid-run must be ignored.
        run_inference(1'b1, lat, order_ok);
        check_run("disturb");

        // Known non-zero output, then reset during POOLING.
        image_input = '0;
        write_bias(10, 0, 0, -8);
        fill_fc(-1);
        run_inference(1'b0, lat, order_ok);
        check("pre_reset_out", $signed(cnn_output), -128);
        @(negedge clk);
        convolution_enable = 1'b0;
        @(negedge clk);
        convolution_enable = 1'b1;
        n = 0;
        while (int'(dut.state) != 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_pooling", 32'(int'(dut.state)), 2);
        rst_cnn = 1'b1;
        @(negedge clk);
        rst_cnn = 1'b0;
        check_cleared("pool_reset");
        clear_model();

        // Reset beats a write and a start in the same IDLE cycle.
        fill_kernel(1, 33);
        fill_kernel(1, 0);
        clear_model();
        for (int k = 0; k < 16; k++) feature_weights_input[k] = 8'd100;
        feature_writeAddr  = 2'd2;
        feature_WrEn       = 1'b0;
        bias_weights_input = '1;
        bias_WrEn          = 1'b0;
        convolution_enable = 1'b0;
        rst_cnn            = 1'b1;
        @(negedge clk);
        rst_cnn            = 1'b0;
        feature_WrEn       = 1'b1;
        bias_WrEn          = 1'b1;
        convolution_enable = 1'b1;
        check_cleared("idle_reset");

        // Cleared weights give a zero score.
        image_input = '1;
        run_inference(1'b0, lat, order_ok);
        check_run("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
